ble_auth_ctrl: RTL and testbench

- Upstream stage of the Segway top level: a UART receiver on the BLE RX line plus a power-authorization state machine, producing pwr_up.
- pwr_up feeds balance_cntrl; rider_off comes back from steer_en.
- The rider powers up with an ASCII 'g' (0x67) and requests shutdown with 's' (0x73).
- Shutdown is deferred while a rider is still on the platform.

---
 rtl/ble_auth_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ble_auth_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ble_auth_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ble_auth_ctrl
// Brief   : BLE UART (8N1) receiver plus power-authorization FSM driving pwr_up.
// Rev     : 1.0  initial release
// ============================================================================
module ble_auth_ctrl #(
    parameter int         BAUD_DIV  = 2604,
    parameter int         HALF_DIV  = BAUD_DIV / 2,
    parameter logic [7:0] GO_BYTE   = 8'h67,
    parameter logic [7:0] STOP_BYTE = 8'h73
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic [7:0] rx_data,
    output logic       rx_rdy
);

    localparam int CW = ($clog2(BAUD_DIV + 1) > 12) ? $clog2(BAUD_DIV + 1) : 12;
    localparam logic [CW-1:0] c_baud_load = CW'(BAUD_DIV);
    localparam logic [CW-1:0] c_half_load = CW'(HALF_DIV);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        PWR_OFF = 2'd0,
        PWR1    = 2'd1,
        PWR2    = 2'd2
    } auth_state_t;

    logic          r_rx_meta, r_rx_s, r_rx_prev;
    rx_state_t     r_rx_state, w_rx_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_rx_data, w_rx_data_nxt;
    logic          r_rx_rdy, w_rx_rdy_nxt;
    auth_state_t   r_auth, w_auth_nxt;
    logic          r_pwr_up;
    logic          w_fall, w_tick, w_go, w_stop;

    assign w_fall = r_rx_prev & ~r_rx_s;
    assign w_tick = (r_cnt == c_cnt_one);
    assign w_go   = r_rx_rdy && (r_rx_data == GO_BYTE);
    assign w_stop = r_rx_rdy && (r_rx_data == STOP_BYTE);

    // Synchronizer and edge-history flops idle high so reset never fakes a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_rx_data  <= 8'h00;
            r_rx_rdy   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_rdy   <= w_rx_rdy_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_cnt_nxt      = r_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_rx_data_nxt  = r_rx_data;
        w_rx_rdy_nxt   = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_cnt_nxt      = c_half_load;
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (r_rx_s) begin
                    w_rx_state_nxt = RX_IDLE;
                end else begin
                    w_cnt_nxt      = c_baud_load;
                    w_bit_cnt_nxt  = 3'd0;
                    w_rx_state_nxt = RX_DATA;
                end
            end
            RX_DATA: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else begin
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_cnt_nxt   = c_baud_load;
                    if (r_bit_cnt == 3'd7) begin
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else begin
                    // A low stop bit is a framing error: drop the byte silently
                    if (r_rx_s) begin
                        w_rx_data_nxt = r_shift;
                        w_rx_rdy_nxt  = 1'b1;
                    end
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auth   <= PWR_OFF;
            r_pwr_up <= 1'b0;
        end else begin
            r_auth   <= w_auth_nxt;
            r_pwr_up <= (w_auth_nxt == PWR1) || (w_auth_nxt == PWR2);
        end
    end

    // A fresh 'go' in PWR2 wins over a simultaneous dismount
    always_comb begin
        w_auth_nxt = r_auth;
        case (r_auth)
            PWR_OFF: if (w_go) w_auth_nxt = PWR1;
            PWR1:    if (w_stop) w_auth_nxt = rider_off ? PWR_OFF : PWR2;
            PWR2: begin
                if (w_go) begin
                    w_auth_nxt = PWR1;
                end else if (rider_off) begin
                    w_auth_nxt = PWR_OFF;
                end
            end
            default: w_auth_nxt = PWR_OFF;
        endcase
    end

    assign pwr_up  = r_pwr_up;
    assign rx_data = r_rx_data;
    assign rx_rdy  = r_rx_rdy;

endmodule
`default_nettype wire

// File: tb/tb_ble_auth_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ble_auth_ctrl
// Brief   : Scoreboard bench for ble_auth_ctrl with a rule-level power model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ble_auth_ctrl;

    localparam int         BAUD_DIV = 16;
    localparam int         LAT_NOM  = 155;
    localparam logic [7:0] GO       = 8'h67;
    localparam logic [7:0] STOP     = 8'h73;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       rider_off = 1'b0;
    logic       pwr_up;
    logic [7:0] rx_data;
    logic       rx_rdy;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        int         fall_cyc;
    } exp_t;
    exp_t sb_q[$];

    ble_auth_ctrl #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .rider_off (rider_off),
        .pwr_up    (pwr_up),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: authorization as two flags updated by rule, not by state encoding
    bit         m_pwr = 1'b0;
    bit         m_wait = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         mon_has;
    logic [7:0] mon_b;
    exp_t       mon_e;
    int         lat;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_pwr  = 1'b0;
            m_wait = 1'b0;
            m_data = 8'h00;
        end else begin
            mon_has = 1'b0;
            check("pwr_up", {31'd0, pwr_up}, {31'd0, m_pwr});
            if (rx_rdy) begin
                if (sb_q.size() == 0) begin
                    check("rx_rdy_unexpected", {31'd0, rx_rdy}, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    lat   = cyc - mon_e.fall_cyc;
                    n_checks++;
                    if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
                        n_fail++;
                        $display("FAIL rx_rdy_latency: got %0d cycles, expected %0d+-1", lat, LAT_NOM);
                    end
                    m_data  = mon_e.data;
                    mon_has = 1'b1;
                    mon_b   = mon_e.data;
                end
            end
            check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
            if (mon_has && mon_b == GO) begin
                m_pwr  = 1'b1;
                m_wait = 1'b0;
            end else if (mon_has && mon_b == STOP && m_pwr && !m_wait) begin
                if (rider_off) m_pwr = 1'b0;
                else           m_wait = 1'b1;
            end else if (m_wait && rider_off) begin
                m_pwr  = 1'b0;
                m_wait = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // rise_at_rdy raises rider_off in the very cycle rx_rdy is expected
    task automatic send_frame(input logic [7:0] b, input bit good_stop, input bit rise_at_rdy);
        if (good_stop) sb_q.push_back('{data: b, fall_cyc: cyc});
        RX = 1'b0;
        tick(BAUD_DIV);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(BAUD_DIV);
        end
        RX = good_stop;
        for (int j = 0; j < BAUD_DIV; j++) begin
            if (rise_at_rdy && j == LAT_NOM - 9 * BAUD_DIV) rider_off = 1'b1;
            tick(1);
        end
        RX = 1'b1;
        tick(2);
    endtask

    initial begin
        logic [7:0] b;
        bit         good;

        tick(3);
        check("reset_pwr_up", {31'd0, pwr_up}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_rdy", {31'd0, rx_rdy}, 32'd0);
        rst_n = 1'b1;
        tick(4);

        rider_off = 1'b0;
        send_frame(GO, 1'b1, 1'b0);
        tick(5);
        check("go_pwr_up", {31'd0, pwr_up}, 32'd1);
        check("go_rx_data", {24'd0, rx_data}, {24'd0, GO});

        send_frame(STOP, 1'b1, 1'b0);
        tick(3);
        check("pwr2_pwr_up", {31'd0, pwr_up}, 32'd1);
        tick(20);
        rider_off = 1'b1;
        tick(1);
        check("dismount_pwr_down", {31'd0, pwr_up}, 32'd0);

        rider_off = 1'b0;
        send_frame(GO, 1'b1, 1'b0);
        rider_off = 1'b1;
        tick(10);
        check("pwr1_ignores_rider_off", {31'd0, pwr_up}, 32'd1);
        send_frame(STOP, 1'b1, 1'b0);
        check("stop_rider_off_pwr_down", {31'd0, pwr_up}, 32'd0);

        rider_off = 1'b0;
        send_frame(GO, 1'b1, 1'b0);
        send_frame(STOP, 1'b1, 1'b0);
        check("in_pwr2", {31'd0, pwr_up}, 32'd1);
        send_frame(GO, 1'b1, 1'b1);
        tick(3);
        check("go_beats_rider_off", {31'd0, pwr_up}, 32'd1);
        tick(10);
        check("pwr1_held", {31'd0, pwr_up}, 32'd1);

        send_frame(STOP, 1'b1, 1'b0);
        check("back_off", {31'd0, pwr_up}, 32'd0);
        send_frame(GO, 1'b0, 1'b0);
        tick(5);
        check("framing_err_pwr", {31'd0, pwr_up}, 32'd0);
        check("framing_err_data", {24'd0, rx_data}, {24'd0, STOP});
        send_frame(GO, 1'b1, 1'b0);
        check("good_after_err", {31'd0, pwr_up}, 32'd1);

        RX = 1'b0;
        tick(3);
        RX = 1'b1;
        tick(40);
        check("glitch_data", {24'd0, rx_data}, {24'd0, GO});
        send_frame(8'h41, 1'b1, 1'b0);
        check("other_byte_data", {24'd0, rx_data}, 32'h41);
        check("other_byte_pwr", {31'd0, pwr_up}, 32'd1);

        RX = 1'b0;
        tick(BAUD_DIV + 30);
        rst_n = 1'b0;
        #1;
        check("midframe_rst_pwr", {31'd0, pwr_up}, 32'd0);
        check("midframe_rst_data", {24'd0, rx_data}, 32'd0);
        check("midframe_rst_rdy", {31'd0, rx_rdy}, 32'd0);
        RX = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        send_frame(GO, 1'b1, 1'b0);
        check("post_rst_data", {24'd0, rx_data}, {24'd0, GO});
        check("post_rst_pwr", {31'd0, pwr_up}, 32'd1);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       b = GO;
                1:       b = STOP;
                default: b = 8'($urandom);
            endcase
            good      = ($urandom_range(0, 4) != 0);
            rider_off = 1'($urandom_range(0, 1));
            send_frame(b, good, 1'b0);
            tick($urandom_range(1, 25));
            if ($urandom_range(0, 2) == 0) rider_off = ~rider_off;
            tick($urandom_range(1, 10));
        end

        tick(20);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
